// File: rtl/gadget_unit.sv
// Falling power-up responder on the collision unit's gadget channel.
// Holds one gadget, steps it down FALL_STEPS pixels per frame and reports catch/loss.
module gadget_unit #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int TYPE_BITS  = 3,
    parameter int FALL_STEPS = 2,
    parameter int Y_BOTTOM   = 479
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_game_start,
    input  logic                 i_cal_frame,
    input  logic                 i_gadget_gen,
    input  logic [X_BITS-1:0]    i_gadget_initX,
    input  logic [Y_BITS-1:0]    i_gadget_initY,
    input  logic [TYPE_BITS-1:0] i_gadget_type,
    input  logic                 i_gadget_req,
    input  logic                 i_gadget_done,
    input  logic                 i_gadget_eaten,
    output logic [X_BITS-1:0]    o_gadgetX,
    output logic [Y_BITS-1:0]    o_gadgetY,
    output logic [1:0]           o_gadget_speedX,
    output logic [1:0]           o_gadget_speedY,
    output logic [TYPE_BITS-1:0] o_gadget_type,
    output logic                 o_gadget_active,
    output logic                 o_gadget_ack,
    output logic                 o_gadget_frame_term,
    output logic                 o_plat_gadget_effect,
    output logic [TYPE_BITS-1:0] o_plat_gadget_type,
    output logic                 o_gadget_lost
);

    localparam int CNT_W = (FALL_STEPS > 1) ? $clog2(FALL_STEPS) : 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(FALL_STEPS - 1);
    localparam logic [Y_BITS-1:0] Y_BOT     = Y_BITS'(Y_BOTTOM);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        MOVE       = 3'd2,
        SERVE      = 3'd3,
        RESULT     = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      step_cnt_q,  step_cnt_d;
    logic [X_BITS-1:0]     x_q,         x_d;
    logic [Y_BITS-1:0]     y_q,         y_d;
    logic [TYPE_BITS-1:0]  type_q,      type_d;
    logic                  active_q,    active_d;
    logic [1:0]            speed_y_q,   speed_y_d;
    logic                  ack_q,       ack_d;
    logic                  term_q,      term_d;
    logic                  effect_q,    effect_d;
    logic [TYPE_BITS-1:0]  plat_type_q, plat_type_d;
    logic                  lost_q,      lost_d;

    // Next-state and output computation; every pulse defaults low each cycle.
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        type_d      = type_q;
        active_d    = active_q;
        plat_type_d = plat_type_q;
        ack_d       = 1'b0;
        term_d      = 1'b0;
        effect_d    = 1'b0;
        lost_d      = 1'b0;

        if (i_game_start) begin
            state_d    = IDLE;
            active_d   = 1'b0;
            step_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_gadget_gen) begin
                        x_d        = i_gadget_initX;
                        y_d        = i_gadget_initY;
                        type_d     = i_gadget_type;
                        active_d   = 1'b1;
                        step_cnt_d = '0;
                        state_d    = i_cal_frame ? MOVE : WAIT_FRAME;
                    end else if (i_cal_frame) begin
                        // Nothing to simulate this frame: finish immediately.
                        term_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_FRAME: begin
                    if (i_cal_frame) begin
                        step_cnt_d = '0;
                        state_d    = MOVE;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
                MOVE: begin
                    if (y_q >= Y_BOT) begin
                        y_d = Y_BOT;
                    end else begin
                        y_d = y_q + Y_BITS'(1);
                    end
                    state_d = SERVE;
                end
                SERVE: begin
                    if (i_gadget_req) begin
                        ack_d   = 1'b1;
                        state_d = RESULT;
                    end else begin
                        state_d = SERVE;
                    end
                end
                RESULT: begin
                    if (!i_gadget_done) begin
                        state_d = RESULT;
                    end else if (i_gadget_eaten) begin
                        effect_d    = 1'b1;
                        plat_type_d = type_q;
                        active_d    = 1'b0;
                        term_d      = 1'b1;
                        state_d     = IDLE;
                    end else if (y_q == Y_BOT) begin
                        lost_d   = 1'b1;
                        active_d = 1'b0;
                        term_d   = 1'b1;
                        state_d  = IDLE;
                    end else if (step_cnt_q == LAST_STEP) begin
                        term_d  = 1'b1;
                        state_d = WAIT_FRAME;
                    end else begin
                        step_cnt_d = step_cnt_q + CNT_W'(1);
                        state_d    = MOVE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            endcase
        end

        speed_y_d = active_d ? 2'b01 : 2'b00;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            type_q      <= '0;
            active_q    <= 1'b0;
            speed_y_q   <= 2'b00;
            ack_q       <= 1'b0;
            term_q      <= 1'b0;
            effect_q    <= 1'b0;
            plat_type_q <= '0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            type_q      <= type_d;
            active_q    <= active_d;
            speed_y_q   <= speed_y_d;
            ack_q       <= ack_d;
            term_q      <= term_d;
            effect_q    <= effect_d;
            plat_type_q <= plat_type_d;
            lost_q      <= lost_d;
        end
    end

    assign o_gadgetX            = x_q;
    assign o_gadgetY            = y_q;
    assign o_gadget_speedX      = 2'b00;
    assign o_gadget_speedY      = speed_y_q;
    assign o_gadget_type        = type_q;
    assign o_gadget_active      = active_q;
    assign o_gadget_ack         = ack_q;
    assign o_gadget_frame_term  = term_q;
    assign o_plat_gadget_effect = effect_q;
    assign o_plat_gadget_type   = plat_type_q;
    assign o_gadget_lost        = lost_q;

endmodule

// File: tb/tb_gadget_unit.sv
// Directed bench for gadget_unit: inputs driven and outputs sampled on the falling edge.
module tb_gadget_unit;

    logic       clk = 1'b0;
    logic       rst, game_start, cal_frame, gen, req, done, eaten;
    logic [9:0] init_x;
    logic [8:0] init_y;
    logic [2:0] init_type;
    logic [9:0] gx;
    logic [8:0] gy;
    logic [1:0] spx, spy;
    logic [2:0] gtype, ptype;
    logic       active, ack, term, effect, lost;

    int runs  = 0;
    int fails = 0;
    int ack_cnt  = 0;
    int term_cnt = 0;

    always #5 clk = ~clk;

    gadget_unit dut (
        .clk(clk), .rst(rst), .i_game_start(game_start), .i_cal_frame(cal_frame),
        .i_gadget_gen(gen), .i_gadget_initX(init_x), .i_gadget_initY(init_y),
        .i_gadget_type(init_type), .i_gadget_req(req), .i_gadget_done(done),
        .i_gadget_eaten(eaten), .o_gadgetX(gx), .o_gadgetY(gy),
        .o_gadget_speedX(spx), .o_gadget_speedY(spy), .o_gadget_type(gtype),
        .o_gadget_active(active), .o_gadget_ack(ack), .o_gadget_frame_term(term),
        .o_plat_gadget_effect(effect), .o_plat_gadget_type(ptype), .o_gadget_lost(lost)
    );

    // Pulse counters, sampled at the rising edge.
    always @(posedge clk) begin
        if (ack)  ack_cnt  <= ack_cnt + 1;
        if (term) term_cnt <= term_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic spawn(input logic [9:0] x, input logic [8:0] y, input logic [2:0] t,
                         input logic with_frame);
        gen = 1'b1; init_x = x; init_y = y; init_type = t; cal_frame = with_frame;
        tick();
        gen = 1'b0; cal_frame = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; game_start = 1'b0; cal_frame = 1'b0; gen = 1'b0; req = 1'b0;
        done = 1'b0; eaten = 1'b0; init_x = 10'd0; init_y = 9'd0; init_type = 3'd0;
        tick(); tick();
        rst = 1'b0;
        runs++;
        if ({gx, gy, spx, spy, gtype, ptype, active, ack, term, effect, lost} !== 37'd0) begin
            $display("FAIL reset_outputs: got %h, want 0",
                     {gx, gy, spx, spy, gtype, ptype, active, ack, term, effect, lost});
            fails++;
        end
    endtask

    task automatic test_two_steps();
        bit seen;
        int a0, t0;
        spawn(10'd100, 9'd200, 3'd3, 1'b0);
        runs++;
        if ({active, gx, gy, gtype, spy, spx} !== {1'b1, 10'd100, 9'd200, 3'd3, 2'b01, 2'b00}) begin
            $display("FAIL spawn_latch: got a=%0b x=%0d y=%0d t=%0d sy=%b sx=%b want 1 100 200 3 01 00",
                     active, gx, gy, gtype, spy, spx);
            fails++;
        end
        a0 = ack_cnt; t0 = term_cnt;
        cal_frame = 1'b1; req = 1'b1;
        tick();
        cal_frame = 1'b0;
        wait_ack(seen);
        runs++;
        if (!seen || gy !== 9'd201) begin
            $display("FAIL step1_ack: seen=%0b y=%0d, want 1 201", seen, gy);
            fails++;
        end
        done = 1'b1; eaten = 1'b0;
        tick();
        done = 1'b0;
        runs++;
        if (term !== 1'b0) begin
            $display("FAIL step1_no_term: got %0b want 0", term);
            fails++;
        end
        wait_ack(seen);
        runs++;
        if (!seen || gy !== 9'd202) begin
            $display("FAIL step2_ack: seen=%0b y=%0d, want 1 202", seen, gy);
            fails++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        runs++;
        if ({term, lost, effect, active} !== 4'b1001) begin
            $display("FAIL step2_term: got term/lost/eff/act=%b want 1001", {term, lost, effect, active});
            fails++;
        end
        tick(); tick(); tick();
        runs++;
        if (ack_cnt - a0 !== 2 || term_cnt - t0 !== 1) begin
            $display("FAIL frame_counts: acks=%0d terms=%0d want 2 1", ack_cnt - a0, term_cnt - t0);
            fails++;
        end
        // A gen while active is ignored.
        spawn(10'd7, 9'd7, 3'd7, 1'b0);
        runs++;
        if ({gx, gy, gtype, active} !== {10'd100, 9'd202, 3'd3, 1'b1}) begin
            $display("FAIL gen_ignored: got x=%0d y=%0d t=%0d want 100 202 3", gx, gy, gtype);
            fails++;
        end
        // Still waiting for a frame: next frame continues the fall.
        cal_frame = 1'b1;
        tick();
        cal_frame = 1'b0;
        wait_ack(seen);
        runs++;
        if (!seen || gy !== 9'd203) begin
            $display("FAIL next_frame_ack: seen=%0b y=%0d want 1 203", seen, gy);
            fails++;
        end
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
    endtask

    task automatic test_eaten();
        bit seen;
        int a0, t0;
        spawn(10'd40, 9'd299, 3'd3, 1'b0);
        a0 = ack_cnt; t0 = term_cnt;
        cal_frame = 1'b1; req = 1'b1;
        tick();
        cal_frame = 1'b0;
        wait_ack(seen);
        runs++;
        if (!seen || gy !== 9'd300) begin
            $display("FAIL eaten_ack: seen=%0b y=%0d want 1 300", seen, gy);
            fails++;
        end
        done = 1'b1; eaten = 1'b1;
        tick();
        done = 1'b0; eaten = 1'b0;
        runs++;
        if ({effect, ptype, active, term, lost, spy} !== {1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 2'b00}) begin
            $display("FAIL eaten_result: got eff=%0b pt=%0d act=%0b term=%0b lost=%0b sy=%b want 1 3 0 1 0 00",
                     effect, ptype, active, term, lost, spy);
            fails++;
        end
        tick();
        runs++;
        if (effect !== 1'b0 || ptype !== 3'd3) begin
            $display("FAIL eaten_pulse_width: got eff=%0b pt=%0d want 0 3", effect, ptype);
            fails++;
        end
        tick(); tick(); tick();
        runs++;
        if (ack_cnt - a0 !== 1 || term_cnt - t0 !== 1) begin
            $display("FAIL eaten_counts: acks=%0d terms=%0d want 1 1", ack_cnt - a0, term_cnt - t0);
            fails++;
        end
    endtask

    task automatic test_lost(input logic [8:0] start_y);
        bit seen;
        spawn(10'd5, start_y, 3'd2, 1'b0);
        cal_frame = 1'b1; req = 1'b1;
        tick();
        cal_frame = 1'b0;
        wait_ack(seen);
        runs++;
        if (!seen || gy !== 9'd479) begin
            $display("FAIL lost_ack: start=%0d seen=%0b y=%0d want 1 479", start_y, seen, gy);
            fails++;
        end
        done = 1'b1; eaten = 1'b0;
        tick();
        done = 1'b0;
        runs++;
        if ({lost, term, active, effect} !== 4'b1100) begin
            $display("FAIL lost_result: start=%0d got lost/term/act/eff=%b want 1100",
                     start_y, {lost, term, active, effect});
            fails++;
        end
        tick();
        runs++;
        if (lost !== 1'b0) begin
            $display("FAIL lost_pulse_width: got %0b want 0", lost);
            fails++;
        end
    endtask

    task automatic test_idle_frame(input string tag);
        int a0;
        a0 = ack_cnt;
        cal_frame = 1'b1;
        tick();
        cal_frame = 1'b0;
        runs++;
        if (term !== 1'b1) begin
            $display("FAIL idle_term_%s: got %0b want 1", tag, term);
            fails++;
        end
        tick();
        runs++;
        if (term !== 1'b0) begin
            $display("FAIL idle_term_width_%s: got %0b want 0", tag, term);
            fails++;
        end
        tick();
        runs++;
        if (ack_cnt !== a0) begin
            $display("FAIL idle_no_ack_%s: got %0d acks want 0", tag, ack_cnt - a0);
            fails++;
        end
    endtask

    task automatic test_gen_with_frame();
        bit seen;
        int t0;
        t0 = term_cnt;
        req = 1'b1;
        spawn(10'd300, 9'd50, 3'd6, 1'b1);
        runs++;
        if (term !== 1'b0) begin
            $display("FAIL gen_frame_no_term: got %0b want 0", term);
            fails++;
        end
        wait_ack(seen);
        runs++;
        if (!seen || gy !== 9'd51 || gtype !== 3'd6) begin
            $display("FAIL gen_frame_ack: seen=%0b y=%0d t=%0d want 1 51 6", seen, gy, gtype);
            fails++;
        end
        tick();
        runs++;
        if (term_cnt !== t0) begin
            $display("FAIL gen_frame_term_count: got %0d want 0", term_cnt - t0);
            fails++;
        end
    endtask

    task automatic test_abort();
        // game_start while waiting for a verdict (left over from test_gen_with_frame).
        game_start = 1'b1; done = 1'b1;
        tick();
        game_start = 1'b0; done = 1'b0;
        runs++;
        if ({active, ack, term, effect, lost} !== 5'b0) begin
            $display("FAIL game_start_abort: got act/ack/term/eff/lost=%b want 0", {active, ack, term, effect, lost});
            fails++;
        end
        test_idle_frame("after_start");
        // Reset while parked in SERVE with no request.
        req = 1'b0;
        spawn(10'd9, 9'd9, 3'd1, 1'b1);
        tick(); tick();
        rst = 1'b1; req = 1'b1;
        tick();
        rst = 1'b0; req = 1'b0;
        runs++;
        if ({active, ack, term, effect, lost, gy, spy} !== 16'd0) begin
            $display("FAIL rst_in_serve: got act=%0b ack=%0b term=%0b y=%0d sy=%b want all 0",
                     active, ack, term, gy, spy);
            fails++;
        end
        test_idle_frame("after_rst");
    endtask

    initial begin
        test_reset();
        test_two_steps();
        test_eaten();
        test_lost(9'd478);
        test_lost(9'd479);
        test_idle_frame("plain");
        test_gen_with_frame();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule

// File: doc/gadget_unit.md
Name: gadget_unit

Overview:
- Responder on the collision unit's gadget channel; the collision unit is the initiator (gadget_req out, gadget_ack/frame_term in).
- Holds at most one falling power-up, spawned when a brick breaks.
- Each frame it advances the gadget in FALL_STEPS 1-pixel steps. For each step it serves one req/ack data transfer, then waits for the collision verdict.
- Reports caught or lost outcomes to the platform and score logic.

Parameters:
- X_BITS, 10, pixel X width
- Y_BITS, 9, pixel Y width
- TYPE_BITS, 3, gadget type width
- FALL_STEPS, 2, 1-pixel steps per frame (>=1)
- Y_BOTTOM, 479, last visible row; reaching it loses the gadget

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- i_game_start  in  1  pulse; clears any gadget
- i_cal_frame  in  1  pulse; start of frame computation
- i_gadget_gen  in  1  pulse; spawn request from collision unit
- i_gadget_initX  in  X_BITS  spawn X
- i_gadget_initY  in  Y_BITS  spawn Y
- i_gadget_type  in  TYPE_BITS  spawn type
- i_gadget_req  in  1  level; collision requests current data
- i_gadget_done  in  1  pulse; collision verdict for this step is valid
- i_gadget_eaten  in  1  qualified by i_gadget_done; platform caught gadget
- o_gadgetX  out  X_BITS  current X
- o_gadgetY  out  Y_BITS  current Y
- o_gadget_speedX  out  2  always 2'b00
- o_gadget_speedY  out  2  2'b01 when active, else 2'b00
- o_gadget_type  out  TYPE_BITS  latched type
- o_gadget_active  out  1  level; a gadget exists
- o_gadget_ack  out  1  one-cycle data-valid pulse
- o_gadget_frame_term  out  1  one-cycle pulse; frame finished
- o_plat_gadget_effect  out  1  one-cycle pulse on catch
- o_plat_gadget_type  out  TYPE_BITS  type caught, held until next catch
- o_gadget_lost  out  1  one-cycle pulse when bottom reached

Behaviour:
- Reset: all outputs 0, state IDLE, step_cnt 0. rst is checked every cycle and wins over everything, including an outstanding ack.
- States: IDLE, WAIT_FRAME, MOVE, SERVE, RESULT.
- IDLE:
  - i_gadget_gen latches X/Y/type, sets active, goes to WAIT_FRAME.
  - i_cal_frame without gen: o_gadget_frame_term pulses the next cycle; stay in IDLE.
  - gen and cal_frame in the same cycle: spawn, then go to MOVE directly. No term pulse yet.
- WAIT_FRAME: i_cal_frame clears step_cnt and goes to MOVE.
- MOVE (1 cycle): Y <= Y+1, saturating at Y_BOTTOM; go to SERVE.
- SERVE:
  - Wait for i_gadget_req=1.
  - Then pulse o_gadget_ack exactly one cycle, with X/Y/speed/type stable that cycle and until the next MOVE.
  - Go to RESULT. The ack is never repeated within one step even if req stays high.
- RESULT: wait for i_gadget_done, then resolve in this priority order:
  - 1) eaten: pulse o_plat_gadget_effect, load o_plat_gadget_type, clear active, pulse frame_term, go IDLE.
  - 2) Y==Y_BOTTOM: pulse o_gadget_lost, clear active, pulse frame_term, go IDLE.
  - 3) step_cnt+1==FALL_STEPS: pulse frame_term, go WAIT_FRAME.
  - 4) otherwise step_cnt++, go MOVE.
- All result pulses occur in the cycle after i_gadget_done.
- i_gadget_gen while active: ignored; the existing gadget is kept.
- i_game_start in any state: go IDLE, clear active, no term/lost/effect pulse. Priority is below rst and above everything else.
- i_cal_frame arriving in MOVE/SERVE/RESULT: ignored (frame overrun).
- Spawn at Y >= Y_BOTTOM: the first MOVE saturates; the first verdict without eaten reports lost.
- speedY is 01 whenever active; X never changes.
- Exactly one frame_term pulse per accepted i_cal_frame, except when cleared by game_start.

Test Plan:
- Spawn at (100,200) type 3, FALL_STEPS=2; cal_frame; hold req high; done with eaten=0 twice -> two ack pulses with Y=201 then 202; frame_term 1 cycle after the 2nd done; state WAIT_FRAME.
- Active gadget at Y=300; first step done with eaten=1 -> o_plat_gadget_effect pulse, o_plat_gadget_type=3, active=0, single frame_term, no second ack.
- Spawn at Y=478; cal_frame -> ack Y=479; done eaten=0 -> o_gadget_lost pulse and frame_term, active=0.
- IDLE; cal_frame -> no ack; frame_term pulse exactly 1 cycle later.
- gen and cal_frame in the same cycle (initY=50) -> ack with Y=51; no early frame_term.
- Assert rst in SERVE, or game_start in RESULT -> next cycle all pulses 0, active=0, IDLE; a following cal_frame gives the IDLE term behaviour.
